// File: rtl/ysyx_041461_div_ctrl.sv
// Divide/remainder sequencing controller between the EX stage and the
// iterative divider. It answers divide-by-zero and signed overflow locally,
// launches the divider for every other operation, and holds the selected,
// sign-extended result until WB accepts it. A flushed divider operation
// cannot be cancelled, so the controller drains it before going idle.
module ysyx_041461_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_rem,
    input  logic            req_signed,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            div_valid_in,
    output logic            div_signed,
    output logic            div_divw,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_valid_out,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic            op_rem;
    logic            op_word;
    logic            accept;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_raw;
    logic [XLEN-1:0] special_data;
    logic [XLEN-1:0] wait_raw;
    logic [XLEN-1:0] wait_data;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = (state == ST_IDLE) && req_valid && !flush;

    // Detect the cases the controller resolves itself; W ops only look at the low words
    always_comb begin
        div_zero     = 1'b0;
        overflow     = 1'b0;
        special_raw  = '0;
        special_data = '0;
        if (req_word) begin
            div_zero = (req_src2[31:0] == 32'd0);
            overflow = req_signed && (req_src1[31:0] == 32'h8000_0000)
                                  && (req_src2[31:0] == 32'hFFFF_FFFF);
        end else begin
            div_zero = (req_src2 == '0);
            overflow = req_signed && (req_src1 == {1'b1, {(XLEN-1){1'b0}}})
                                  && (req_src2 == '1);
        end
        if (req_is_rem) begin
            special_raw = div_zero ? req_src1 : '0;
        end else begin
            special_raw = div_zero ? '1 : req_src1;
        end
        special_data = req_word ? {{(XLEN-32){special_raw[31]}}, special_raw[31:0]}
                                : special_raw;
    end

    assign special = div_zero || overflow;

    // Pick quotient or remainder from the divider and sign-extend W results
    always_comb begin
        wait_raw  = op_rem ? div_remainder : div_quotient;
        wait_data = op_word ? {{(XLEN-32){wait_raw[31]}}, wait_raw[31:0]} : wait_raw;
    end

    // Next-state selection; flush always wins over completion or WB acceptance
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = special ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next = div_valid_out ? ST_IDLE : ST_DRAIN;
                end else if (div_valid_out) begin
                    state_next = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (div_valid_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush || resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, operand latches, launch pulse and the held response
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_rem       <= 1'b0;
            op_word      <= 1'b0;
            div_valid_in <= 1'b0;
            div_signed   <= 1'b0;
            div_divw     <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
        end else begin
            state        <= state_next;
            div_valid_in <= (state_next == ST_LAUNCH);
            resp_valid   <= (state_next == ST_DONE);
            if (accept) begin
                op_rem       <= req_is_rem;
                op_word      <= req_word;
                div_signed   <= req_signed;
                div_divw     <= req_word;
                div_dividend <= req_src1;
                div_divisor  <= req_src2;
                if (special) begin
                    resp_data <= special_data;
                end
            end
            if ((state == ST_WAIT) && div_valid_out && !flush) begin
                resp_data <= wait_data;
            end
        end
    end

endmodule

// File: doc/ysyx_041461_div_ctrl.md
Name: ysyx_041461_div_ctrl

Overview:
Sequencing controller between the EX stage and the iterative divider.
- Accepts RISC-V M-extension divide/remainder requests (DIV/DIVU/REM/REMU and W forms) through a valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally without using the divider.
- Otherwise launches the divider, waits for completion, then selects, sign-extends and holds the result until WB accepts it.
- Handles pipeline flush, including draining an in-flight divider operation that cannot be cancelled.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  EX presents a divide request
req_ready  output  1  controller can accept a request
req_is_rem  input  1  1=REM*, 0=DIV*
req_signed  input  1  1=signed op
req_word  input  1  1=*W op (32-bit operands, sign-extended result)
req_src1  input  64  dividend
req_src2  input  64  divisor
flush  input  1  kill the current request/response
resp_valid  output  1  result available
resp_ready  input  1  WB accepts the result
resp_data  output  64  final result
busy  output  1  state != IDLE
div_valid_in  output  1  one-cycle launch pulse to the divider
div_signed  output  1  registered op signedness
div_divw  output  1  registered word flag
div_dividend  output  64  registered operand
div_divisor  output  64  registered operand
div_valid_out  input  1  divider completion
div_quotient  input  64  divider quotient
div_remainder  input  64  divider remainder

Behaviour:
Reset:
- On rst (synchronous, any state, including mid-operation), go to IDLE.
- All registered outputs reset to 0: div_valid_in, div_signed, div_divw, div_dividend, div_divisor, resp_valid, resp_data.
- An in-flight divider result arriving after reset is ignored; IDLE never samples div_valid_out.

State IDLE:
- req_ready=1.
- Accept when req_valid & ~flush.
- Latch op flags and operands.
- Special-case check on the effective operands (low 32 bits when req_word):
  - divisor==0: quotient=all ones; remainder=dividend.
  - Signed overflow (dividend==most-negative, divisor==-1): quotient=dividend; remainder=0.
  - Select quotient or remainder by is_rem. If req_word, sign-extend bit 31 (applies to signed and unsigned W ops).
  - Go to DONE with resp_data loaded.
- Non-special: go to LAUNCH.

State LAUNCH (exactly 1 cycle):
- div_valid_in=1; div_* operand and flag outputs hold the latched values and stay stable until the next accept.
- Next state WAIT; DRAIN if flush.

State WAIT:
- On div_valid_out: resp_data = (is_rem ? div_remainder : div_quotient), sign-extended from bit 31 if word; go to DONE.
- flush without div_valid_out: go to DRAIN.
- flush with div_valid_out in the same cycle: go to IDLE and discard the result.

State DRAIN:
- req_ready=0.
- On div_valid_out: discard the result and go to IDLE.

State DONE:
- resp_valid=1; resp_data stable.
- resp_ready: go to IDLE.
- flush has priority over resp_ready: go to IDLE, response dropped.

General rules:
- req_ready=1 only in IDLE; no new request is accepted in the cycle DONE exits.
- Latency, with accept at cycle T:
  - Special case: resp_valid at T+1.
  - Normal: div_valid_in at T+1; earliest div_valid_out sampled at T+2; resp_valid at T+3.
- div_valid_out is sampled only in WAIT and DRAIN.
- div_valid_in is never asserted outside LAUNCH.

Test Plan:
- DIVW src1=0x0000_0000_FFFF_FFF9 (-7), src2=0x2, divider returns quotient 0xFFFF_FFFF_FFFF_FFFD at T+2 -> resp_data=0xFFFF_FFFF_FFFF_FFFD, resp_valid at T+3, div_valid_in high only at T+1.
- REMU src1=100, src2=0 -> resp_data=100 at T+1, div_valid_in never asserted.
- DIV src1=0x8000_0000_0000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> resp_data=0x8000_0000_0000_0000 at T+1; REMW with low words 0x8000_0000 and 0xFFFF_FFFF -> resp_data=0.
- DIVUW src1=0xFFFF_FFFF, src2=1, divider quotient 0x0000_0000_FFFF_FFFF -> resp_data=0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- Normal op with flush at LAUNCH; divider completes 5 cycles later -> state DRAIN, req_ready=0 until div_valid_out, no resp_valid, then IDLE; a following request completes correctly.
- resp_ready held low 4 cycles in DONE -> resp_valid and resp_data stable; rst asserted in WAIT -> all outputs 0 next cycle, later div_valid_out ignored.
